// File: rtl/mem_fill_pkg.sv
// Shared types for the memory fill engine: pattern selector and FSM states.
package mem_fill_pkg;

    typedef enum logic [1:0] {
        MODE_IDENTITY   = 2'd0,
        MODE_CONSTANT   = 2'd1,
        MODE_DESCENDING = 2'd2,
        MODE_XOR        = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/mem_fill_pattern.sv
// Combinational pattern generator: maps (mode, address, fill value) to RAM data.
// The address is zero-extended or truncated to DATA_W before use.
module mem_fill_pattern
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  mode_t             mode_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] fill_value_i,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] addr_ext;

    assign addr_ext = DATA_W'(addr_i);

    // Select the data word for the current address.
    always_comb begin
        data_o = addr_ext;
        case (mode_i)
            MODE_IDENTITY:   data_o = addr_ext;
            MODE_CONSTANT:   data_o = fill_value_i;
            // addr never exceeds LAST_ADDR, so this cannot underflow
            MODE_DESCENDING: data_o = DATA_W'(LAST_ADDR - addr_i);
            MODE_XOR:        data_o = addr_ext ^ fill_value_i;
            default:         data_o = addr_ext;
        endcase
    end

endmodule

// File: rtl/mem_fill_engine.sv
// Fills an address window of a single-port RAM with a selected pattern.
// Start/done handshake, arbiter grant stalls, abort stops early, and
// windows running past DEPTH are rejected without writing.
//
//   state  | meaning
//   IDLE   | waiting for start; done/error/aborted cleared
//   WRITE  | issuing one write per granted cycle
//   FINISH | one cycle before the done pulse
module mem_fill_engine
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              grant,
    input  logic              abort,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              aborted
);

    localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    state_t             state_q,   state_d;
    mode_t              mode_q,    mode_d;
    logic [DATA_W-1:0]  fill_q,    fill_d;
    logic [ADDR_W-1:0]  base_q,    base_d;
    logic [ADDR_W:0]    len_q,     len_d;
    logic [ADDR_W:0]    cnt_q,     cnt_d;
    logic               err_q,     err_d;
    logic               abt_q,     abt_d;
    logic [ADDR_W-1:0]  addr_q,    addr_d;
    logic [DATA_W-1:0]  data_q,    data_d;
    logic               wren_q,    wren_d;
    logic               done_q,    done_d;
    logic               error_q,   error_d;
    logic               aborted_q, aborted_d;

    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  pat_data;
    logic               out_of_range;

    // cnt stays below len_q <= DEPTH while writing, so the low bits suffice
    assign wr_addr = base_q + cnt_q[ADDR_W-1:0];

    // Sum is widened by two bits so base+length can never wrap before the compare.
    assign out_of_range = ({2'b00, base_addr} + {1'b0, length}) > DEPTH_EXT;

    mem_fill_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_pattern (
        .mode_i       (mode_q),
        .addr_i       (wr_addr),
        .fill_value_i (fill_q),
        .data_o       (pat_data)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        fill_d    = fill_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        abt_d     = abt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode_t'(mode);
                    fill_d = fill_value;
                    base_d = base_addr;
                    len_d  = length;
                    cnt_d  = '0;
                    abt_d  = 1'b0;
                    if ((length == '0) || out_of_range) begin
                        // zero length is a legal no-op, not an error
                        err_d   = (length != '0);
                        state_d = FINISH;
                    end else begin
                        err_d   = 1'b0;
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = FINISH;
                end else if (grant) begin
                    wren_d = 1'b1;
                    addr_d = wr_addr;
                    data_d = pat_data;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == (len_q - CNT_ONE)) begin
                        state_d = FINISH;
                    end
                end
            end

            FINISH: begin
                done_d    = 1'b1;
                error_d   = err_q;
                aborted_d = abt_q;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= MODE_IDENTITY;
            fill_q    <= '0;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            abt_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            fill_q    <= fill_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            abt_q     <= abt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            done_q    <= done_d;
            error_q   <= error_d;
            aborted_q <= aborted_d;
        end
    end

    assign ram_address = addr_q;
    assign ram_data    = data_q;
    assign ram_wren    = wren_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_mem_fill_engine.sv
// Self-checking bench for mem_fill_engine: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, and
// randomized fills.
module tb_mem_fill_engine;

    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] fill_value = 8'd0;
    logic [7:0] base_addr = 8'd0;
    logic [8:0] length = 9'd0;
    logic       grant = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic       busy;
    logic       done;
    logic       error;
    logic       aborted;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    mem_fill_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .fill_value  (fill_value),
        .base_addr   (base_addr),
        .length      (length),
        .grant       (grant),
        .abort       (abort),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Pattern straight from the data rules, on integer addresses.
    function automatic logic [7:0] pat(input int m, input int a, input logic [7:0] f);
        logic [7:0] a8;
        a8 = 8'(a);
        case (m)
            0:       return a8;
            1:       return f;
            2:       return 8'(DEPTH - 1 - a);
            default: return a8 ^ f;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // A request becomes a list of pending (addr,data) writes; each granted
    // cycle consumes one entry, then one cycle later done is reported.
    int   qa[$];
    int   qd[$];
    bit   m_active = 0, m_fin = 0, m_err = 0, m_abt = 0;
    logic e_busy = 0, e_wren = 0, e_done = 0, e_error = 0, e_aborted = 0;
    logic [7:0] e_addr = 0, e_data = 0;

    always @(posedge clk or posedge reset) begin
        int b, l;
        if (reset) begin
            qa.delete(); qd.delete();
            m_active = 0; m_fin = 0; m_err = 0; m_abt = 0;
            e_busy = 0; e_wren = 0; e_done = 0; e_error = 0; e_aborted = 0;
            e_addr = 0; e_data = 0;
        end else begin
            e_wren = 0; e_done = 0; e_error = 0; e_aborted = 0;
            if (m_fin) begin
                e_done = 1; e_error = m_err; e_aborted = m_abt; m_fin = 0;
            end else if (m_active) begin
                if (abort) begin
                    m_active = 0; m_fin = 1; m_abt = 1;
                    qa.delete(); qd.delete();
                end else if (grant) begin
                    e_wren = 1;
                    e_addr = 8'(qa.pop_front());
                    e_data = 8'(qd.pop_front());
                    if (qa.size() == 0) begin
                        m_active = 0; m_fin = 1;
                    end
                end
            end else if (start) begin
                b = int'(base_addr);
                l = int'(length);
                m_abt = 0; m_err = 0;
                if (l == 0 || b + l > DEPTH) begin
                    m_fin = 1;
                    m_err = (l != 0);
                end else begin
                    for (int i = 0; i < l; i++) begin
                        qa.push_back(b + i);
                        qd.push_back(int'(pat(int'(mode), b + i, fill_value)));
                    end
                    m_active = 1;
                end
            end
            e_busy = m_active || m_fin;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",        32'(busy),        32'(e_busy));
            chk("ram_wren",    32'(ram_wren),    32'(e_wren));
            chk("ram_address", 32'(ram_address), 32'(e_addr));
            chk("ram_data",    32'(ram_data),    32'(e_data));
            chk("done",        32'(done),        32'(e_done));
            chk("error",       32'(error),       32'(e_error));
            chk("aborted",     32'(aborted),     32'(e_aborted));
        end
    end

    // ---------------- driver ----------------
    int seen_a[$];
    int seen_d[$];
    int r_nw, r_cyc;
    logic r_err, r_abt;

    function automatic int sa(input int i);
        return (i < seen_a.size()) ? seen_a[i] : -1;
    endfunction
    function automatic int sd(input int i);
        return (i < seen_d.size()) ? seen_d[i] : -1;
    endfunction

    function automatic logic gval(input int gm, input int gi);
        case (gm)
            0:       return 1'b1;
            1:       return (gi % 3) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_addr"},    32'(ram_address), 0);
        chk({tag, "_data"},    32'(ram_data),    0);
        chk({tag, "_wren"},    32'(ram_wren),    0);
        chk({tag, "_busy"},    32'(busy),        0);
        chk({tag, "_done"},    32'(done),        0);
        chk({tag, "_error"},   32'(error),       0);
        chk({tag, "_aborted"}, 32'(aborted),     0);
    endtask

    // r_cyc = edges from the start-sampling edge E0 to the edge that raises done.
    task automatic run_fill(input int md, input logic [7:0] fv, input int ba, input int ln,
                            input int gmode, input int abort_at, input int reset_at,
                            input bit pulse_start);
        int  k, gi;
        bit  fin, was_reset;
        seen_a.delete(); seen_d.delete();
        r_nw = 0; r_cyc = -1; r_err = 1'bx; r_abt = 1'bx;
        @(posedge clk); #2;
        start = 1'b1; mode = 2'(md); fill_value = fv;
        base_addr = 8'(ba); length = 9'(ln); abort = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        // scramble request inputs: the engine must use its latched copy
        mode = 2'($urandom); fill_value = 8'($urandom);
        base_addr = 8'($urandom); length = 9'($urandom);
        k = 0; gi = 0; fin = 0; was_reset = 0;
        while (!fin && k < 3000) begin
            grant = gval(gmode, gi);
            gi++;
            start = (pulse_start && k == 10);
            @(posedge clk); #2;
            k++;
            start = 1'b0;
            if (ram_wren) begin
                seen_a.push_back(int'(ram_address));
                seen_d.push_back(int'(ram_data));
                r_nw++;
            end
            if (done) begin
                fin = 1; r_cyc = k; r_err = error; r_abt = aborted;
            end else if (reset_at >= 0 && r_nw == reset_at) begin
                reset = 1'b1;
                #1;
                check_zero_outputs("async_reset");
                repeat (3) begin
                    @(posedge clk); #2;
                    if (ram_wren) r_nw++;
                end
                reset = 1'b0;
                fin = 1; was_reset = 1;
            end else if (abort_at >= 0 && r_nw == abort_at) begin
                abort = 1'b1;
            end
        end
        abort = 1'b0;
        grant = 1'b0;
        if (!fin) chk("run_timeout", 32'(k), 0);
        if (!was_reset) begin
            @(posedge clk); #2;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ok, ba, ln, md, ab;
        logic [7:0] fv;

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        cmp_en = 1'b1;
        #1;
        reset = 1'b0;

        // full identity fill
        run_fill(0, 8'h00, 0, 256, 0, -1, -1, 0);
        chk("id_count", 32'(r_nw), 256);
        chk("id_done_edge", 32'(r_cyc), 257);
        chk("id_error", 32'(r_err), 0);
        ok = 1;
        for (int i = 0; i < 256; i++) if (sa(i) != i || sd(i) != i) ok = 0;
        chk("id_sequence", 32'(ok), 1);

        // constant 0xA5 at 16..19
        run_fill(1, 8'hA5, 16, 4, 0, -1, -1, 0);
        chk("const_count", 32'(r_nw), 4);
        chk("const_addr0", 32'(sa(0)), 16);
        chk("const_addr3", 32'(sa(3)), 19);
        chk("const_data0", 32'(sd(0)), 32'hA5);
        chk("const_data3", 32'(sd(3)), 32'hA5);

        // descending at the top of memory
        run_fill(2, 8'h00, 254, 2, 0, -1, -1, 0);
        chk("desc_count", 32'(r_nw), 2);
        chk("desc_addr0", 32'(sa(0)), 254);
        chk("desc_data0", 32'(sd(0)), 1);
        chk("desc_addr1", 32'(sa(1)), 255);
        chk("desc_data1", 32'(sd(1)), 0);

        // grant 1,0,0 repeating: 8 writes over 22 edges, 14 stalls
        run_fill(0, 8'h00, 0, 8, 1, -1, -1, 0);
        chk("stall_count", 32'(r_nw), 8);
        chk("stall_done_edge", 32'(r_cyc), 23);
        ok = 1;
        for (int i = 0; i < 8; i++) if (sa(i) != i || sd(i) != i) ok = 0;
        chk("stall_no_dup", 32'(ok), 1);

        // out-of-range request
        run_fill(0, 8'h00, 250, 10, 0, -1, -1, 0);
        chk("range_writes", 32'(r_nw), 0);
        chk("range_done_edge", 32'(r_cyc), 1);
        chk("range_error", 32'(r_err), 1);

        // zero length
        run_fill(0, 8'h00, 40, 0, 0, -1, -1, 0);
        chk("zero_writes", 32'(r_nw), 0);
        chk("zero_done_edge", 32'(r_cyc), 1);
        chk("zero_error", 32'(r_err), 0);

        // exact fit at the last address
        run_fill(3, 8'h3C, 200, 56, 0, -1, -1, 0);
        chk("fit_count", 32'(r_nw), 56);
        chk("fit_last_addr", 32'(sa(55)), 255);
        chk("fit_error", 32'(r_err), 0);

        // XOR with abort after the 5th write
        run_fill(3, 8'h0F, 0, 20, 0, 5, -1, 0);
        chk("abort_count", 32'(r_nw), 5);
        chk("abort_flag", 32'(r_abt), 1);
        chk("abort_error", 32'(r_err), 0);
        chk("abort_data0", 32'(sd(0)), 32'h0F);
        chk("abort_data4", 32'(sd(4)), 32'h0B);

        // reset in the middle of a full fill
        run_fill(0, 8'h00, 0, 256, 0, -1, 100, 0);
        chk("reset_writes", 32'(r_nw), 100);

        // full fill again, with a start pulse while busy that must be ignored
        run_fill(0, 8'h00, 0, 256, 0, -1, -1, 1);
        chk("post_reset_count", 32'(r_nw), 256);
        ok = 1;
        for (int i = 0; i < 256; i++) if (sa(i) != i || sd(i) != i) ok = 0;
        chk("post_reset_sequence", 32'(ok), 1);

        // randomized fills, checked by the model
        for (int t = 0; t < 30; t++) begin
            md = int'($urandom_range(0, 3));
            fv = 8'($urandom);
            ba = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ln = int'($urandom_range(0, 300));
            else ln = int'($urandom_range(0, DEPTH - ba));
            if (ln > 40 && $urandom_range(0, 1) == 1) ln = 40 - (ln % 7);
            ab = -1;
            if (ln > 2 && ba + ln <= DEPTH && $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(1, ln - 1));
            run_fill(md, fv, ba, ln, 2, ab, -1, 0);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
